// File: rtl/rate_divider_ctrl.sv
// Purpose: tick generator for the display counter; free-running divided ticks (RUN) or one tick per key press (STOP).
// Latency: RUN first tick P(speed) edges after entry; STOP step tick 3 edges after the key falls (3+DB_CYCLES with RATE_DIV_DEBOUNCE_EN).
// Backpressure: none; tick is a one-cycle enable the counter must take on the cycle it is high.
module rate_divider_ctrl #(
    parameter int CNT_W     = 28,
    parameter int PERIOD1   = 50_000_000,
    parameter int PERIOD2   = 100_000_000,
    parameter int PERIOD3   = 200_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic       step_n,
    output logic       tick,
    output logic       running
);

    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

    // Reload values are period-1 because the count includes the cycle that sees zero.
    localparam logic [CNT_W-1:0] RLD1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] RLD2 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] RLD3 = CNT_W'(PERIOD3 - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] reload;
    logic             tick_nxt;
    logic [1:0]       speed_q;
    logic             s1;
    logic             s2;
    logic             level;
    logic             prev;
    logic             fall;

    // Reload value for the currently selected rate; speed 0 means a tick every cycle.
    always_comb begin
        reload = '0;
        case (speed)
            2'd1:    reload = RLD1;
            2'd2:    reload = RLD2;
            2'd3:    reload = RLD3;
            default: reload = '0;
        endcase
    end

    // Two-flop synchronizer for the raw key; idles high so reset never looks like a press.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= step_n;
            s2 <= s1;
        end
    end

`ifdef RATE_DIV_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt;
    logic            db;

    // Filtered level follows s2 only after s2 has differed from it for DB_CYCLES straight cycles;
    // any return to the filtered level (a bounce) restarts the count.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            db_cnt <= '0;
            db     <= 1'b1;
        end else if (s2 == db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_cnt <= '0;
            db     <= s2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = db;
`else
    assign level = s2;
`endif

    // Edge-detect register: one-cycle fall pulse per press, however long the key is held.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign fall = prev & ~level;

    // State register plus the registered datapath and outputs.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state   <= ST_STOP;
            cnt     <= '0;
            tick    <= 1'b0;
            running <= 1'b0;
            speed_q <= 2'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tick    <= tick_nxt;
            running <= (state_nxt == ST_RUN);
            speed_q <= speed;
        end
    end

    // Next state follows the run switch directly.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: state_nxt = run ? ST_RUN : ST_STOP;
            ST_RUN:  state_nxt = run ? ST_RUN : ST_STOP;
            default: state_nxt = ST_STOP;
        endcase
    end

    // Counter and tick decisions; entering RUN or changing rate restarts a full period.
    always_comb begin
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        case (state)
            ST_STOP: begin
                if (run) begin
                    cnt_nxt = reload;
                end else begin
                    tick_nxt = fall;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    cnt_nxt = cnt;
                end else if (speed != speed_q) begin
                    cnt_nxt = reload;
                end else if (cnt == '0) begin
                    tick_nxt = 1'b1;
                    cnt_nxt  = reload;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                cnt_nxt  = cnt;
                tick_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rate_divider_ctrl.sv
// Purpose: directed checks of rate_divider_ctrl with small periods (4/8/16) and DB_CYCLES=3.
// Latency: outputs sampled 1 ns after each rising edge; inputs change at the same point.
// Backpressure: none; the bench drives one vector per clock.
module tb_rate_divider_ctrl;

    localparam int DB = 3;
`ifdef RATE_DIV_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic       clock;
    logic       clear_b;
    logic       run;
    logic [1:0] speed;
    logic       step_n;
    logic       tick;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       run;
        logic [1:0] speed;
        logic       step_n;
        logic       exp_tick;
        logic       exp_running;
    } vec_t;

    vec_t vecs[$];

    rate_divider_ctrl #(
        .CNT_W     (5),
        .PERIOD1   (4),
        .PERIOD2   (8),
        .PERIOD3   (16),
        .DB_CYCLES (DB)
    ) dut (
        .clock   (clock),
        .clear_b (clear_b),
        .run     (run),
        .speed   (speed),
        .step_n  (step_n),
        .tick    (tick),
        .running (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void add(input logic r, input logic [1:0] sp, input logic sn,
                                input logic et, input logic er);
        vec_t v;
        v.run = r;
        v.speed = sp;
        v.step_n = sn;
        v.exp_tick = et;
        v.exp_running = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic et, input logic er);
        n_tests++;
        if ({tick, running} !== {et, er}) begin
            n_fail++;
            $display("FAIL %s: got tick=%0b running=%0b, expected tick=%0b running=%0b",
                     nm, tick, running, et, er);
        end
    endtask

    // Apply inputs, advance one edge, compare.
    task automatic cyc(input logic r, input logic [1:0] sp, input logic sn,
                       input logic et, input logic er, input string nm);
        run = r;
        speed = sp;
        step_n = sn;
        @(posedge clock);
        #1;
        check(nm, et, er);
    endtask

    initial begin
        clear_b = 1'b0;
        run     = 1'b0;
        speed   = 2'd0;
        step_n  = 1'b1;

        // Main table: enter RUN at speed 1, switch to 0, then 3, then stop/restart mid-count.
        add(1, 1, 1, 0, 1);                                     // edge 0: entering edge
        for (int k = 1; k <= 12; k++) add(1, 1, 1, (k % 4) == 0, 1);
        add(1, 0, 1, 0, 1);                                     // rate change: reload, no tick
        for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 1);         // tick every cycle
        for (int k = 0; k < 16; k++) add(1, 3, 1, 0, 1);        // reload edge + 15 quiet
        add(1, 3, 1, 1, 1);                                     // 16th edge after reload
        add(1, 3, 1, 0, 1);
        add(1, 1, 1, 0, 1);                                     // reload to 3
        add(1, 1, 1, 0, 1);                                     // cnt = 2
        for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 0);         // STOP for 5 cycles
        add(1, 1, 1, 0, 1);                                     // re-entry reloads
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 1);                                     // 4 edges after re-entry

        // Reset state, checked across a clock edge while held.
        @(posedge clock);
        #1;
        check("reset_state", 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_state_held", 1'b0, 1'b0);
        clear_b = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            cyc(vecs[i].run, vecs[i].speed, vecs[i].step_n,
                vecs[i].exp_tick, vecs[i].exp_running, $sformatf("table[%0d]", i));

        // Key presses in RUN are ignored; leaving RUN afterwards gives no stale tick.
        for (int k = 1; k <= 15; k++)
            cyc(1, 3, (k <= 8) ? 1'b0 : 1'b1, 0, 1, $sformatf("run_step_ignored[%0d]", k));
        for (int k = 1; k <= 7; k++) cyc(0, 3, 1, 0, 0, $sformatf("stop_no_stale[%0d]", k));

        // Single step: held key gives exactly one tick; release, press again gives another.
        for (int k = 1; k <= 10; k++) cyc(0, 3, 0, k == LAT, 0, $sformatf("step_press[%0d]", k));
        for (int k = 1; k <= 8; k++) cyc(0, 3, 1, 0, 0, $sformatf("step_release[%0d]", k));
        for (int k = 1; k <= 9; k++) cyc(0, 3, 0, k == LAT, 0, $sformatf("step_press2[%0d]", k));
        for (int k = 1; k <= 8; k++) cyc(0, 3, 1, 0, 0, $sformatf("step_release2[%0d]", k));

        // run rises on the same edge the press would tick: RUN wins, no step tick.
        for (int k = 1; k <= LAT; k++)
            cyc(k == LAT, 3, 0, 0, k == LAT, $sformatf("step_vs_run[%0d]", k));
        for (int k = 1; k <= 3; k++) cyc(1, 3, 0, 0, 1, $sformatf("after_vs_run[%0d]", k));
        for (int k = 1; k <= 8; k++) cyc(0, 3, 1, 0, 0, $sformatf("settle[%0d]", k));

`ifdef RATE_DIV_DEBOUNCE_EN
        // A 2-cycle glitch is filtered; a 6-cycle press ticks once at 3+DB edges.
        for (int k = 1; k <= 12; k++)
            cyc(0, 3, (k <= 2) ? 1'b0 : 1'b1, 0, 0, $sformatf("db_glitch[%0d]", k));
        for (int k = 1; k <= 10; k++)
            cyc(0, 3, (k <= 6) ? 1'b0 : 1'b1, k == 6, 0, $sformatf("db_press[%0d]", k));
        for (int k = 1; k <= 8; k++) cyc(0, 3, 1, 0, 0, $sformatf("db_settle[%0d]", k));
`else
        // Without the filter even a one-cycle low is taken as a press.
        for (int k = 1; k <= 8; k++)
            cyc(0, 3, (k == 1) ? 1'b0 : 1'b1, k == 3, 0, $sformatf("short_press[%0d]", k));
`endif

        // Async clear while tick is high in RUN at speed 0.
        cyc(1, 0, 1, 0, 1, "enter_fast");
        for (int k = 1; k <= 3; k++) cyc(1, 0, 1, 1, 1, $sformatf("fast_tick[%0d]", k));
        clear_b = 1'b0;
        #2;
        check("async_clear", 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("clear_held", 1'b0, 1'b0);
        clear_b = 1'b1;
        for (int k = 1; k <= 6; k++) cyc(0, 0, 1, 0, 0, $sformatf("post_reset[%0d]", k));

        // Fresh RUN at speed 2 counts a full 8-cycle period.
        cyc(1, 2, 1, 0, 1, "enter_speed2");
        for (int k = 1; k <= 9; k++) cyc(1, 2, 1, k == 8, 1, $sformatf("speed2[%0d]", k));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
